// File: rtl/uart_rx_sampler_pkg.sv
// rtl/uart_rx_sampler_pkg.sv - shared FSM encoding and oversampling constants
package uart_rx_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_MID = 4'd7;
    localparam logic [3:0] SAMPLE_END = 4'd15;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - host-side mode, buffer and status signals of the receiver
interface uart_rx_sampler_if;

    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic       clear_errs;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    modport master (
        output bit8, parity_en, odd_n_even, read_rx_byte, clear_errs,
        input  rx_data, data_ready, parity_err, framing_err, overflow
    );

    modport slave (
        input  bit8, parity_en, odd_n_even, read_rx_byte, clear_errs,
        output rx_data, data_ready, parity_err, framing_err, overflow
    );

endinterface

// File: rtl/uart_rx_sampler_sync_vote.sv
// rtl/uart_rx_sampler_sync_vote.sv - rx synchronizer plus tick-enabled 3-tap majority vote
module uart_rx_sync_vote #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic baud_clock,
    input  logic rx,
    output logic rx_s,
    output logic rx_prev,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        hist_d = hist_q;
        if (baud_clock) begin
            hist_d = {hist_q[1:0], rx_s};
        end
    end

    // Both preset high so an idle line never looks like a start edge out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_prev = hist_q[0];
    assign vote    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversampled async frame receiver with one-entry byte buffer
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RX_LEGACY   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_clock,
    input  logic              rx,
    uart_rx_sampler_if.slave  host
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             bit8_q, bit8_d;
    logic             parity_en_q, parity_en_d;
    logic             odd_q, odd_d;
    logic             par_bad_q, par_bad_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             data_ready_q, data_ready_d;
    logic             parity_err_q, parity_err_d;
    logic             framing_err_q, framing_err_d;
    logic             overflow_q, overflow_d;
    logic             commit;
    logic             rx_s, rx_prev, vote;

    uart_rx_sync_vote #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vote (
        .clk        (clk),
        .reset      (reset),
        .baud_clock (baud_clock),
        .rx         (rx),
        .rx_s       (rx_s),
        .rx_prev    (rx_prev),
        .vote       (vote)
    );

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        bit8_d      = bit8_q;
        parity_en_d = parity_en_q;
        odd_d       = odd_q;
        par_bad_d   = par_bad_q;
        commit      = 1'b0;
        if (baud_clock) begin
            samp_cnt_d = samp_cnt_q + 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    samp_cnt_d = '0;
                    // Edge, not level: a held-low break cannot retrigger.
                    if (!rx_s && rx_prev) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (samp_cnt_q == SAMPLE_MID) begin
                        samp_cnt_d = '0;
                        if (!vote) begin
                            state_d     = ST_DATA;
                            bit_idx_d   = '0;
                            shreg_d     = '0;
                            bit8_d      = host.bit8;
                            parity_en_d = host.parity_en;
                            odd_d       = host.odd_n_even;
                            par_bad_d   = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (samp_cnt_q == SAMPLE_END) begin
                        shreg_d[bit_idx_q] = vote;
                        bit_idx_d          = bit_idx_q + 1'b1;
                        if (bit_idx_q == {2'b11, bit8_q}) begin
                            state_d = parity_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp_cnt_q == SAMPLE_END) begin
                        par_bad_d = vote ^ (^shreg_q) ^ odd_q;
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (samp_cnt_q == SAMPLE_END) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d     = rx_data_q;
        data_ready_d  = data_ready_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overflow_d    = overflow_q;
        if (host.read_rx_byte) begin
            data_ready_d = 1'b0;
        end
        if (host.clear_errs) begin
            overflow_d = 1'b0;
            if (RX_LEGACY) begin
                parity_err_d  = 1'b0;
                framing_err_d = 1'b0;
            end
        end
        // Commit is applied last so a simultaneous clear loses to a fresh overflow.
        if (commit) begin
            rx_data_d     = bit8_q ? shreg_q : {1'b0, shreg_q[6:0]};
            data_ready_d  = 1'b1;
            parity_err_d  = (RX_LEGACY ? parity_err_d : 1'b0) | (par_bad_q & parity_en_q);
            framing_err_d = (RX_LEGACY ? framing_err_d : 1'b0) | ~vote;
            if (data_ready_q && !host.read_rx_byte) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            samp_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            bit8_q        <= 1'b0;
            parity_en_q   <= 1'b0;
            odd_q         <= 1'b0;
            par_bad_q     <= 1'b0;
            rx_data_q     <= '0;
            data_ready_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            bit8_q        <= bit8_d;
            parity_en_q   <= parity_en_d;
            odd_q         <= odd_d;
            par_bad_q     <= par_bad_d;
            rx_data_q     <= rx_data_d;
            data_ready_q  <= data_ready_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign host.rx_data     = rx_data_q;
    assign host.data_ready  = data_ready_q;
    assign host.parity_err  = parity_err_q;
    assign host.framing_err = framing_err_q;
    assign host.overflow    = overflow_q;

endmodule
